// File: rtl/trace_line_checker.sv
// -----------------------------------------------------------------------------
// trace_line_checker
//
// Per-character parser/checker for CPU trace lines, one ASCII character per
// clock. Two line shapes are recognised:
//   register write : ^T@PPPPPPPP: $R <= DDDDDDDD#
//   memory write   : ^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#
// When the closing '#' arrives on a well-formed line, the captured fields, the
// line format and a legality vector are published for one-cycle 'valid'. The
// published values are held until the next accepted line.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   char         ASCII character, one per cycle
//   freq         clock-period reference, latched on the first time digit
//   valid        one-cycle pulse: a line was accepted
//   format_type  00 none, 01 register write, 10 memory write (held)
//   error_code   [0] time, [1] pc, [2] addr, [3] grf legality errors (held)
//   time_val     captured time field
//   pc_val       captured PC
//   dest_val     register index (zero-extended) or store address
//   data_val     captured data
//   line_count   accepted-line counter, wraps 16'hffff -> 0
// -----------------------------------------------------------------------------
module trace_line_checker #(
  parameter int          TIME_DIGITS = 4,
  parameter int          REG_DIGITS  = 2,
  parameter int          FREQ_W      = 16,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2ffc,
  parameter int          GRF_COUNT   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [FREQ_W-1:0] freq,
  output logic              valid,
  output logic [1:0]        format_type,
  output logic [3:0]        error_code,
  output logic [31:0]       time_val,
  output logic [31:0]       pc_val,
  output logic [31:0]       dest_val,
  output logic [31:0]       data_val,
  output logic [15:0]       line_count
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CARET = 4'd1,
    S_TIME  = 4'd2,
    S_AT    = 4'd3,
    S_PC    = 4'd4,
    S_COLON = 4'd5,
    S_SP1   = 4'd6,
    S_SIGIL = 4'd7,
    S_DEST  = 4'd8,
    S_SP2   = 4'd9,
    S_LT    = 4'd10,
    S_EQ    = 4'd11,
    S_SP3   = 4'd12,
    S_DATA  = 4'd13
  } state_t;

  localparam logic [7:0] CH_CARET = 8'h5e; // '^'
  localparam logic [7:0] CH_AT    = 8'h40; // '@'
  localparam logic [7:0] CH_COLON = 8'h3a; // ':'
  localparam logic [7:0] CH_SPACE = 8'h20; // ' '
  localparam logic [7:0] CH_DOLLR = 8'h24; // '$'
  localparam logic [7:0] CH_STAR  = 8'h2a; // '*'
  localparam logic [7:0] CH_LT    = 8'h3c; // '<'
  localparam logic [7:0] CH_EQ    = 8'h3d; // '='
  localparam logic [7:0] CH_HASH  = 8'h23; // '#'

  localparam logic [7:0]  TIME_LIM = 8'(TIME_DIGITS);
  localparam logic [7:0]  REG_LIM  = 8'(REG_DIGITS);
  localparam logic [7:0]  HEX_LIM  = 8'd8;
  localparam logic [31:0] GRF_LIM  = 32'(GRF_COUNT);

  // Decimal digit '0'-'9'.
  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Lowercase hex digit; uppercase is deliberately rejected.
  function automatic logic is_hex(input logic [7:0] c);
    return is_digit(c) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Nibble value of a character already known to be a hex digit.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [3:0] v;
    if (is_digit(c)) begin
      v = c[3:0];
    end else begin
      v = c[3:0] + 4'd9;
    end
    return v;
  endfunction

  // Parser state and field accumulators
  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                mode_q, mode_d;      // 1: memory write, 0: register write
  logic [FREQ_W-1:0]   freq_lat_q, freq_lat_d;
  logic [31:0]         time_q, time_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         dest_q, dest_d;
  logic [31:0]         data_q, data_d;

  // Published results
  logic                valid_q, valid_d;
  logic [1:0]          format_q, format_d;
  logic [3:0]          err_q, err_d;
  logic [31:0]         time_val_q, time_val_d;
  logic [31:0]         pc_val_q, pc_val_d;
  logic [31:0]         dest_val_q, dest_val_d;
  logic [31:0]         data_val_q, data_val_d;
  logic [15:0]         line_count_q, line_count_d;

  // Legality checks on the captured fields
  logic [31:0] half_s;
  logic        time_err_s;
  logic        pc_err_s;
  logic        addr_err_s;
  logic        grf_err_s;
  logic [3:0]  nib_s;
  logic [3:0]  dig_s;

  // Legality vector evaluated on the current accumulators; only used on accept.
  always_comb begin
    half_s     = 32'(freq_lat_q >> 1);
    // freq is a power of two, so half-1 masks the bits that must be clear
    // for the time stamp to be a whole multiple of half a period.
    time_err_s = (half_s == 32'd0) || ((time_q & (half_s - 32'd1)) != 32'd0);
    pc_err_s   = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
    addr_err_s = mode_q && ((dest_q[1:0] != 2'b00) || (dest_q > ADDR_HI));
    grf_err_s  = !mode_q && (dest_q >= GRF_LIM);
    nib_s      = hex_val(char);
    dig_s      = char[3:0];
  end

  // Next-state, field capture and accept logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    freq_lat_d   = freq_lat_q;
    time_d       = time_q;
    pc_d         = pc_q;
    dest_d       = dest_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    format_d     = format_q;
    err_d        = err_q;
    time_val_d   = time_val_q;
    pc_val_d     = pc_val_q;
    dest_val_d   = dest_val_q;
    data_val_d   = data_val_q;
    line_count_d = line_count_q;

    // '^' is never legal inside a line, so it always (re)starts one.
    if (char == CH_CARET) begin
      state_d = S_CARET;
      cnt_d   = 8'd0;
      mode_d  = 1'b0;
      time_d  = 32'd0;
      pc_d    = 32'd0;
      dest_d  = 32'd0;
      data_d  = 32'd0;
    end else begin
      // Anything not matched below abandons the line.
      state_d = S_IDLE;
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_CARET: begin
          if (is_digit(char)) begin
            state_d    = S_TIME;
            cnt_d      = 8'd1;
            time_d     = {28'd0, dig_s};
            freq_lat_d = freq;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_TIME: begin
          if (is_digit(char) && (cnt_q < TIME_LIM)) begin
            state_d = S_TIME;
            cnt_d   = cnt_q + 8'd1;
            time_d  = (time_q * 32'd10) + {28'd0, dig_s};
          end else if (char == CH_AT) begin
            state_d = S_AT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_AT: begin
          if (is_hex(char)) begin
            state_d = S_PC;
            cnt_d   = 8'd1;
            pc_d    = {28'd0, nib_s};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PC: begin
          if (is_hex(char) && (cnt_q < HEX_LIM)) begin
            state_d = S_PC;
            cnt_d   = cnt_q + 8'd1;
            pc_d    = {pc_q[27:0], nib_s};
          end else if ((char == CH_COLON) && (cnt_q == HEX_LIM)) begin
            state_d = S_COLON;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_COLON, S_SP1: begin
          if (char == CH_SPACE) begin
            state_d = S_SP1;
          end else if (char == CH_DOLLR) begin
            state_d = S_SIGIL;
            mode_d  = 1'b0;
          end else if (char == CH_STAR) begin
            state_d = S_SIGIL;
            mode_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SIGIL: begin
          if (!mode_q && is_digit(char)) begin
            state_d = S_DEST;
            cnt_d   = 8'd1;
            dest_d  = {28'd0, dig_s};
          end else if (mode_q && is_hex(char)) begin
            state_d = S_DEST;
            cnt_d   = 8'd1;
            dest_d  = {28'd0, nib_s};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DEST: begin
          if (!mode_q) begin
            // Register index accumulates in decimal.
            if (is_digit(char) && (cnt_q < REG_LIM)) begin
              state_d = S_DEST;
              cnt_d   = cnt_q + 8'd1;
              dest_d  = (dest_q * 32'd10) + {28'd0, dig_s};
            end else if (char == CH_SPACE) begin
              state_d = S_SP2;
            end else if (char == CH_LT) begin
              state_d = S_LT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            // Store address must be exactly eight hex digits.
            if (is_hex(char) && (cnt_q < HEX_LIM)) begin
              state_d = S_DEST;
              cnt_d   = cnt_q + 8'd1;
              dest_d  = {dest_q[27:0], nib_s};
            end else if ((char == CH_SPACE) && (cnt_q == HEX_LIM)) begin
              state_d = S_SP2;
            end else if ((char == CH_LT) && (cnt_q == HEX_LIM)) begin
              state_d = S_LT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_SP2: begin
          if (char == CH_SPACE) begin
            state_d = S_SP2;
          end else if (char == CH_LT) begin
            state_d = S_LT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LT: begin
          if (char == CH_EQ) begin
            state_d = S_EQ;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EQ, S_SP3: begin
          if (char == CH_SPACE) begin
            state_d = S_SP3;
          end else if (is_hex(char)) begin
            state_d = S_DATA;
            cnt_d   = 8'd1;
            data_d  = {28'd0, nib_s};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (is_hex(char) && (cnt_q < HEX_LIM)) begin
            state_d = S_DATA;
            cnt_d   = cnt_q + 8'd1;
            data_d  = {data_q[27:0], nib_s};
          end else if ((char == CH_HASH) && (cnt_q == HEX_LIM)) begin
            state_d      = S_IDLE;
            valid_d      = 1'b1;
            format_d     = mode_q ? 2'b10 : 2'b01;
            err_d        = {grf_err_s, addr_err_s, pc_err_s, time_err_s};
            time_val_d   = time_q;
            pc_val_d     = pc_q;
            dest_val_d   = dest_q;
            data_val_d   = data_q;
            line_count_d = line_count_q + 16'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      mode_q       <= 1'b0;
      freq_lat_q   <= '0;
      time_q       <= 32'd0;
      pc_q         <= 32'd0;
      dest_q       <= 32'd0;
      data_q       <= 32'd0;
      valid_q      <= 1'b0;
      format_q     <= 2'b00;
      err_q        <= 4'b0000;
      time_val_q   <= 32'd0;
      pc_val_q     <= 32'd0;
      dest_val_q   <= 32'd0;
      data_val_q   <= 32'd0;
      line_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      freq_lat_q   <= freq_lat_d;
      time_q       <= time_d;
      pc_q         <= pc_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      format_q     <= format_d;
      err_q        <= err_d;
      time_val_q   <= time_val_d;
      pc_val_q     <= pc_val_d;
      dest_val_q   <= dest_val_d;
      data_val_q   <= data_val_d;
      line_count_q <= line_count_d;
    end
  end

  assign valid       = valid_q;
  assign format_type = format_q;
  assign error_code  = err_q;
  assign time_val    = time_val_q;
  assign pc_val      = pc_val_q;
  assign dest_val    = dest_val_q;
  assign data_val    = data_val_q;
  assign line_count  = line_count_q;

endmodule

// File: tb/tb_trace_line_checker.sv
// -----------------------------------------------------------------------------
// tb_trace_line_checker
//
// Directed bench for trace_line_checker. Expected accept results are pushed to
// a scoreboard queue before each line is driven; a negedge monitor pops and
// compares them whenever valid is seen, including the accept latency.
// -----------------------------------------------------------------------------
module tb_trace_line_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic [15:0] freq;
  logic        valid;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  logic [31:0] time_val;
  logic [31:0] pc_val;
  logic [31:0] dest_val;
  logic [31:0] data_val;
  logic [15:0] line_count;

  trace_line_checker dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .valid       (valid),
    .format_type (format_type),
    .error_code  (error_code),
    .time_val    (time_val),
    .pc_val      (pc_val),
    .dest_val    (dest_val),
    .data_val    (data_val),
    .line_count  (line_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [3:0]  err;
    logic [31:0] t;
    logic [31:0] pc;
    logic [31:0] dest;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          due_q[$];
  exp_t        mon_e;
  int          mon_due;
  logic [15:0] exp_count;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        prev_valid = 1'b0;

  // Cycle counter used to check accept latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      chk("pulse_width", {31'd0, prev_valid}, 32'd0);
      chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        mon_e   = sb.pop_front();
        mon_due = due_q.pop_front();
        chk("latency",     32'(cyc),             32'(mon_due));
        chk("format_type", {30'd0, format_type}, {30'd0, mon_e.fmt});
        chk("error_code",  {28'd0, error_code},  {28'd0, mon_e.err});
        chk("time_val",    time_val,             mon_e.t);
        chk("pc_val",      pc_val,               mon_e.pc);
        chk("dest_val",    dest_val,             mon_e.dest);
        chk("data_val",    data_val,             mon_e.data);
        chk("line_count",  {16'd0, line_count},  {16'd0, mon_e.cnt});
      end
    end
    prev_valid = valid;
  end

  task automatic expect_line(input logic [1:0] fmt, input logic [3:0] err,
                             input logic [31:0] t, input logic [31:0] pc,
                             input logic [31:0] dest, input logic [31:0] data);
    exp_t e;
    exp_count = exp_count + 16'd1;
    e = '{fmt, err, t, pc, dest, data, exp_count};
    sb.push_back(e);
  endtask

  // Drive one character per cycle; optionally change freq after index chg_at.
  task automatic send(input string s, input int chg_at, input logic [15:0] chg_freq,
                      input bit accept);
    for (int i = 0; i < s.len(); i++) begin
      char = s[i];
      if (accept && (i == s.len() - 1)) due_q.push_back(cyc + 1);
      @(negedge clk);
      if (i == chg_at) freq = chg_freq;
    end
  endtask

  task automatic idle(input int n);
    char = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"},  {31'd0, valid},       32'd0);
    chk({tag, "_format"}, {30'd0, format_type}, 32'd0);
    chk({tag, "_error"},  {28'd0, error_code},  32'd0);
    chk({tag, "_time"},   time_val,             32'd0);
    chk({tag, "_pc"},     pc_val,               32'd0);
    chk({tag, "_dest"},   dest_val,             32'd0);
    chk({tag, "_data"},   data_val,             32'd0);
    chk({tag, "_count"},  {16'd0, line_count},  32'd0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_count = 16'd0;
    reset = 1'b1;
    char  = 8'h00;
    freq  = 16'd16;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    idle(1);

    // Register write, all legal.
    freq = 16'd16;
    expect_line(2'b01, 4'b0000, 32'd40, 32'h3000, 32'd4, 32'h0000abcd);
    send("^40@00003000: $4 <= 0000abcd#", -1, 16'd0, 1'b1);
    idle(2);

    // Memory writes: address above ADDR_HI, then also odd time.
    freq = 16'd4;
    expect_line(2'b10, 4'b0100, 32'd10, 32'h3004, 32'h3000, 32'h12345678);
    send("^10@00003004: *00003000 <= 12345678#", -1, 16'd0, 1'b1);
    idle(2);
    expect_line(2'b10, 4'b0101, 32'd11, 32'h3004, 32'h3000, 32'h12345678);
    send("^11@00003004: *00003000 <= 12345678#", -1, 16'd0, 1'b1);
    idle(2);

    // Register index out of range; PC below range and misaligned.
    freq = 16'd16;
    expect_line(2'b01, 4'b1000, 32'd16, 32'h3000, 32'd32, 32'h1);
    send("^16@00003000: $32 <= 00000001#", -1, 16'd0, 1'b1);
    idle(2);
    expect_line(2'b01, 4'b0010, 32'd16, 32'h2ffe, 32'd1, 32'h1);
    send("^16@00002ffe: $1 <= 00000001#", -1, 16'd0, 1'b1);
    idle(2);

    // Malformed lines: none may be accepted.
    send("^12345@00003000:$0<=00000000#", -1, 16'd0, 1'b0);
    idle(1);
    send("^8@0000300:$0<=00000000#", -1, 16'd0, 1'b0);
    idle(1);
    send("^8@00003000:$0<=0000A000#", -1, 16'd0, 1'b0);
    idle(1);
    send("^8@00003000:$0<=0000000#", -1, 16'd0, 1'b0);
    idle(2);
    chk("count_after_malformed", {16'd0, line_count}, 32'd5);

    // freq=1 gives half==0, always a time error.
    freq = 16'd1;
    expect_line(2'b01, 4'b0001, 32'd8, 32'h3000, 32'd0, 32'd0);
    send("^8@00003000:$0<=00000000#", -1, 16'd0, 1'b1);
    idle(2);

    // Restart in the middle of a line.
    freq = 16'd16;
    expect_line(2'b01, 4'b0000, 32'd8, 32'h3000, 32'd0, 32'd0);
    send("^12@0000^8@00003000:$0<=00000000#", -1, 16'd0, 1'b1);
    idle(2);

    // Back-to-back lines; freq change after first digit of the second is ignored.
    freq = 16'd4;
    expect_line(2'b10, 4'b0000, 32'd4, 32'h3ffc, 32'h2ffc, 32'hdeadbeef);
    expect_line(2'b01, 4'b0000, 32'd7, 32'h6ffc, 32'd31, 32'hffffffff);
    send("^4@00003ffc: *00002ffc <= deadbeef#", -1, 16'd0, 1'b1);
    freq = 16'd2;
    send("^7@00006ffc:$31<=ffffffff#", 1, 16'd16, 1'b1);
    idle(2);
    chk("count_after_b2b", {16'd0, line_count}, 32'd9);

    // Reset during the data field discards the line and clears outputs.
    freq = 16'd16;
    send("^8@00003000:$0<=0000", -1, 16'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midline_reset");
    reset = 1'b0;
    exp_count = 16'd0;
    send("0000#", -1, 16'd0, 1'b0);
    idle(2);
    chk("count_after_reset", {16'd0, line_count}, 32'd0);

    // Counter wrap: preload the counter to its maximum.
    force dut.line_count_q = 16'hffff;
    @(negedge clk);
    release dut.line_count_q;
    exp_count = 16'hffff;
    expect_line(2'b01, 4'b0000, 32'd8, 32'h3000, 32'd0, 32'd0);
    send("^8@00003000:$0<=00000000#", -1, 16'd0, 1'b1);
    idle(2);
    expect_line(2'b10, 4'b0100, 32'd32, 32'h3000, 32'h2, 32'd0);
    send("^32@00003000: *00000002 <= 00000000#", -1, 16'd0, 1'b1);

    // Bounded drain of anything still expected.
    idle(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
